// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Sits between the CPU store path and the UART transmitter. It buffers byte
//   stores in a small FIFO and launches them toward the transmitter one at a
//   time. Each launch is a single-cycle uart_wr pulse, and consecutive launches
//   are spaced by one frame time.
//
//   Ports
//     CLK       system clock, rising edge
//     RST       asynchronous reset, active-high
//     wr_en     store strobe for the UART data address
//     wr_data   byte to transmit
//     ovf_clr   clears the sticky overflow flag
//     uart_wr   one-cycle launch pulse to the transmitter
//     uart_dat  launched byte; holds its last value between pulses
//     full      level == DEPTH
//     empty     level == 0
//     level     bytes queued and not yet launched
//     busy      a frame is still timing out, or bytes are queued
//     overflow  sticky; a store was dropped because the FIFO was full
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no frame timing out; launch as soon as a byte is queued
//   S_WAIT | frame time running; next launch allowed when timer hits 0
module uart_tx_sched #(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int CLKS_PER_BYTE = 8680
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              ovf_clr,
    output logic              uart_wr,
    output logic [7:0]        uart_dat,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              overflow
);

    localparam int                TMR_W    = $clog2(CLKS_PER_BYTE);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(CLKS_PER_BYTE - 1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [TMR_W-1:0]    timer_q;
    logic [ADDR_W-1:0]   wptr_q;
    logic [ADDR_W-1:0]   rptr_q;
    logic [ADDR_W:0]     level_q;
    logic [7:0]          mem [DEPTH];

    logic launch;
    logic push;
    logic drop;
    logic timer_zero;
    logic queued;

    // full is taken from the pre-edge level, so a store arriving while full
    // is dropped even if a launch frees a slot on the same edge.
    assign full       = (level_q == LVL_FULL);
    assign empty      = (level_q == '0);
    assign level      = level_q;
    assign queued     = (level_q != '0);
    assign busy       = (state_q != S_IDLE) || queued;
    assign push       = wr_en && !full;
    assign drop       = wr_en && full;
    assign timer_zero = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (queued) begin
                    launch  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timer_zero) begin
                    if (queued) begin
                        launch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
            overflow <= 1'b0;
        end else begin
            uart_wr <= launch;

            if (launch) begin
                timer_q  <= TMR_LOAD;
                uart_dat <= mem[rptr_q];
                rptr_q   <= rptr_q + ADDR_W'(1);
            end else if ((state_q == S_WAIT) && !timer_zero) begin
                timer_q <= timer_q - TMR_W'(1);
            end

            if (push) begin
                wptr_q <= wptr_q + ADDR_W'(1);
            end

            case ({push, launch})
                2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
                default: level_q <= level_q;
            endcase

            // A new drop wins over a clear on the same edge.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Bench for uart_tx_sched with DEPTH=4, ADDR_W=2, CLKS_PER_BYTE=16.
//   The reference keeps a byte queue and the cycle number of the last
//   launch. A launch happens on an edge when the queue is non-empty and at
//   least one frame time has passed since the previous launch.
module tb_uart_tx_sched;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int CPB    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              ovf_clr = 1'b0;
    logic              uart_wr;
    logic [7:0]        uart_dat;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              busy;
    logic              overflow;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .CLKS_PER_BYTE(CPB)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .ovf_clr(ovf_clr),
        .uart_wr(uart_wr),
        .uart_dat(uart_dat),
        .full(full),
        .empty(empty),
        .level(level),
        .busy(busy),
        .overflow(overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [7:0] m_dat;
    logic       m_wr;
    logic       m_ovf;
    int         cyc;
    int         last;
    string      phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0h expected=%0h at cycle %0d", phase, tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dat = 8'h00;
        m_wr  = 1'b0;
        m_ovf = 1'b0;
        cyc   = 0;
        last  = -1000;
    endtask

    task automatic check_all();
        chk("uart_wr",  32'(uart_wr),  32'(m_wr));
        chk("uart_dat", 32'(uart_dat), 32'(m_dat));
        chk("level",    32'(level),    32'(q.size()));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("busy",     32'(busy),     32'((q.size() != 0) || ((cyc - last) < CPB)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Drive inputs for one edge, advance the reference, then check outputs.
    task automatic step(input logic we, input logic [7:0] d, input logic clr);
        bit full_pre;
        bit launch;
        wr_en   = we;
        wr_data = d;
        ovf_clr = clr;
        @(posedge clk);
        cyc++;
        full_pre = (q.size() == DEPTH);
        launch   = (q.size() != 0) && ((cyc - last) >= CPB);
        m_wr     = launch;
        if (launch) begin
            m_dat = q.pop_front();
            last  = cyc;
        end
        if (we && full_pre) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (we && !full_pre) q.push_back(d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        phase = "reset";
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        phase = "t1_single";
        step(1'b1, 8'h41, 1'b0);
        chk("t1_level", 32'(level), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_pulse", 32'(uart_wr), 32'd1);
        chk("t1_data", 32'(uart_dat), 32'h41);
        idle(15);
        chk("t1_busy_before", 32'(busy), 32'd1);
        idle(1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        idle(20);

        phase = "t2_burst";
        step(1'b1, 8'h10, 1'b0);
        chk("t2_lvl0", 32'(level), 32'd1);
        step(1'b1, 8'h11, 1'b0);
        chk("t2_lvl1", 32'(level), 32'd1);
        step(1'b1, 8'h12, 1'b0);
        chk("t2_lvl2", 32'(level), 32'd2);
        idle(60);

        phase = "t3_overflow";
        for (int i = 0; i < 6; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        idle(30);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        idle(70);

        phase = "t4_full_pop";
        // Continuous stores keep the FIFO full across several launch edges.
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h5A, 1'b1);
        idle(80);

        phase = "t5_reset";
        step(1'b1, 8'hB0, 1'b0);
        step(1'b1, 8'hB1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        chk("t5_queued", 32'(level), 32'd2);
        idle(4);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        idle(32);

        phase = "t6_wrap";
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b0);
            idle(19);
        end

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
